// File: rtl/alu_arbiter_if.sv
// One requester's link to the shared ALU: operands plus a valid/ready handshake.
// The requester drives valid/a/b/op and holds them stable until it sees ready.
interface alu_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int OP_W   = 3
);
   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;
   logic [OP_W-1:0]   op;

   modport master (output valid, output a, output b, output op, input ready);
   modport slave  (input valid, input a, input b, input op, output ready);
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin share of one combinational ALU between two requesters; the result shows up one cycle after the grant.
// A full response buffer that is not being drained holds both readies low; draining it and reloading it happen in the same cycle.
module alu_arbiter #(
   parameter int DATA_W   = 32,
   parameter int OP_W     = 3,
   parameter int STATUS_W = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   alu_arbiter_if.slave        req0,
   alu_arbiter_if.slave        req1,
   output logic [DATA_W-1:0]   alu_a,
   output logic [DATA_W-1:0]   alu_b,
   output logic [OP_W-1:0]     alu_op,
   input  logic [DATA_W-1:0]   alu_out,
   input  logic [STATUS_W-1:0] alu_status,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_out,
   output logic [STATUS_W-1:0] rsp_status,
   output logic                rsp_id
);

   typedef enum logic {IDLE, FULL} state_t;

   state_t state_q, state_d;
   logic   rr_ptr_q;
   logic   can_issue;
   logic   gnt0, gnt1, gnt_any, winner;

   always_comb begin
      can_issue = 1'b0;
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      alu_a     = '0;
      alu_b     = '0;
      alu_op    = '0;
      state_d   = state_q;

      // Readies stay low during reset so nothing is accepted and then dropped.
      can_issue = rst_n & ((state_q == IDLE) | rsp_ready);
      if (can_issue) begin
         if (req0.valid & req1.valid) begin
            gnt0 = ~rr_ptr_q;
            gnt1 = rr_ptr_q;
         end else begin
            gnt0 = req0.valid;
            gnt1 = req1.valid;
         end
      end
      gnt_any = gnt0 | gnt1;
      winner  = gnt1;

      if (gnt0) begin
         alu_a  = req0.a;
         alu_b  = req0.b;
         alu_op = req0.op;
      end else if (gnt1) begin
         alu_a  = req1.a;
         alu_b  = req1.b;
         alu_op = req1.op;
      end

      if (gnt_any) begin
         state_d = FULL;
      end else if ((state_q == FULL) && rsp_ready) begin
         state_d = IDLE;
      end
   end

   assign req0.ready = gnt0;
   assign req1.ready = gnt1;
   assign rsp_valid  = (state_q == FULL);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         rr_ptr_q   <= 1'b0;
         rsp_out    <= '0;
         rsp_status <= '0;
         rsp_id     <= 1'b0;
      end else begin
         state_q <= state_d;
         // Pointer moves only on a grant, so a lone requester cannot bank turns.
         if (gnt_any) begin
            rsp_out    <= alu_out;
            rsp_status <= alu_status;
            rsp_id     <= winner;
            rr_ptr_q   <= ~winner;
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed per-cycle vectors for alu_arbiter with a behavioural ALU attached,
// plus a bounded wait on the round-robin fairness.
module tb_alu_arbiter;

   logic        clk;
   logic        rst_n;
   logic [31:0] alu_a, alu_b, alu_out, rsp_out;
   logic [2:0]  alu_op, alu_status, rsp_status;
   logic        rsp_valid, rsp_ready, rsp_id;

   alu_arbiter_if req0_if ();
   alu_arbiter_if req1_if ();

   alu_arbiter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0       (req0_if),
      .req1       (req1_if),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_out    (alu_out),
      .alu_status (alu_status),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_out    (rsp_out),
      .rsp_status (rsp_status),
      .rsp_id     (rsp_id)
   );

   // Shifts move b by a[4:0]
   always_comb begin
      alu_out = '0;
      case (alu_op)
         3'd0: alu_out = alu_a + alu_b;
         3'd1: alu_out = alu_a - alu_b;
         3'd2: alu_out = alu_a & alu_b;
         3'd3: alu_out = alu_a | alu_b;
         3'd4: alu_out = alu_a ^ alu_b;
         3'd5: alu_out = alu_b << alu_a[4:0];
         3'd6: alu_out = alu_b >> alu_a[4:0];
         default: alu_out = 32'($signed(alu_b) >>> alu_a[4:0]);
      endcase
      alu_status = {alu_a < alu_b, $signed(alu_a) < $signed(alu_b), alu_a == alu_b};
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rn;
      logic        v0;
      logic [31:0] a0, b0;
      logic [2:0]  op0;
      logic        v1;
      logic [31:0] a1, b1;
      logic [2:0]  op1;
      logic        rr;
      logic [1:0]  e_rdy;
      logic [31:0] e_alu_a;
      logic        e_vld;
      logic [31:0] e_out;
      logic [2:0]  e_st;
      logic        e_id;
   } vec_t;

   vec_t vecs[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic add(input logic rn, input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                      input logic [2:0] op0, input logic v1, input logic [31:0] a1, input logic [31:0] b1,
                      input logic [2:0] op1, input logic rr, input logic [1:0] e_rdy,
                      input logic [31:0] e_alu_a, input logic e_vld, input logic [31:0] e_out,
                      input logic [2:0] e_st, input logic e_id);
      vec_t v;
      v.rn = rn; v.v0 = v0; v.a0 = a0; v.b0 = b0; v.op0 = op0;
      v.v1 = v1; v.a1 = a1; v.b1 = b1; v.op1 = op1; v.rr = rr;
      v.e_rdy = e_rdy; v.e_alu_a = e_alu_a; v.e_vld = e_vld;
      v.e_out = e_out; v.e_st = e_st; v.e_id = e_id;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   initial begin
      int found;
      rst_n = 1'b0; rsp_ready = 1'b0;
      req0_if.valid = 0; req0_if.a = 0; req0_if.b = 0; req0_if.op = 0;
      req1_if.valid = 0; req1_if.a = 0; req1_if.b = 0; req1_if.op = 0;

      //  rn v0  a0     b0        op  v1  a1     b1            op  rr  rdy    alu_a   vld out           st      id
      add(0, 1, 32'd5,  32'd7,    0, 1, 32'd1, 32'd1,        0, 1, 2'b00, 32'd0,  0, 32'd0,        3'b000, 0);
      add(1, 1, 32'd5,  32'd7,    0, 0, 32'd0, 32'd0,        0, 1, 2'b01, 32'd5,  1, 32'd12,       3'b110, 0);
      add(1, 0, 32'd0,  32'd0,    0, 0, 32'd0, 32'd0,        0, 1, 2'b00, 32'd0,  0, 32'd12,       3'b110, 0);
      add(0, 0, 32'd0,  32'd0,    0, 0, 32'd0, 32'd0,        0, 1, 2'b00, 32'd0,  0, 32'd0,        3'b000, 0);
      add(1, 1, 32'd10, 32'd3,    1, 1, 32'hF0, 32'hFF,      4, 1, 2'b01, 32'd10, 1, 32'd7,        3'b000, 0);
      add(1, 1, 32'd10, 32'd3,    1, 1, 32'hF0, 32'hFF,      4, 1, 2'b10, 32'hF0, 1, 32'h0F,       3'b110, 1);
      add(1, 1, 32'd10, 32'd3,    1, 1, 32'hF0, 32'hFF,      4, 1, 2'b01, 32'd10, 1, 32'd7,        3'b000, 0);
      add(1, 1, 32'd10, 32'd3,    1, 1, 32'hF0, 32'hFF,      4, 1, 2'b10, 32'hF0, 1, 32'h0F,       3'b110, 1);
      add(1, 0, 32'd0,  32'd0,    0, 1, 32'd4, 32'h80000000, 7, 1, 2'b10, 32'd4,  1, 32'hF8000000, 3'b100, 1);
      add(1, 1, 32'd1,  32'd2,    0, 0, 32'd0, 32'd0,        0, 0, 2'b00, 32'd0,  1, 32'hF8000000, 3'b100, 1);
      add(1, 1, 32'd1,  32'd2,    0, 0, 32'd0, 32'd0,        0, 0, 2'b00, 32'd0,  1, 32'hF8000000, 3'b100, 1);
      add(1, 1, 32'd1,  32'd2,    0, 0, 32'd0, 32'd0,        0, 0, 2'b00, 32'd0,  1, 32'hF8000000, 3'b100, 1);
      add(1, 1, 32'd1,  32'd2,    0, 0, 32'd0, 32'd0,        0, 1, 2'b01, 32'd1,  1, 32'd3,        3'b110, 0);
      add(0, 1, 32'hFF, 32'h0F,   2, 1, 32'h10, 32'h01,      3, 1, 2'b00, 32'd0,  0, 32'd0,        3'b000, 0);
      add(1, 1, 32'hFF, 32'h0F,   2, 1, 32'h10, 32'h01,      3, 1, 2'b01, 32'hFF, 1, 32'h0F,       3'b000, 0);
      add(1, 0, 32'd0,  32'd0,    0, 1, 32'd4, 32'd1,        5, 1, 2'b10, 32'd4,  1, 32'h10,       3'b000, 1);
      add(1, 0, 32'd0,  32'd0,    0, 1, 32'd1, 32'd8,        6, 1, 2'b10, 32'd1,  1, 32'd4,        3'b110, 1);
      add(1, 0, 32'd0,  32'd0,    0, 1, 32'd3, 32'd5,        1, 1, 2'b10, 32'd3,  1, 32'hFFFFFFFE, 3'b110, 1);
      add(1, 0, 32'd0,  32'd0,    0, 1, 32'd7, 32'd7,        0, 1, 2'b10, 32'd7,  1, 32'd14,       3'b001, 1);
      add(1, 1, 32'h10, 32'h01,   3, 1, 32'hFF, 32'h0F,      2, 1, 2'b01, 32'h10, 1, 32'h11,       3'b000, 0);
      add(1, 1, 32'h10, 32'h01,   3, 1, 32'hFF, 32'h0F,      2, 1, 2'b10, 32'hFF, 1, 32'h0F,       3'b000, 1);
      add(1, 0, 32'd0,  32'd0,    0, 0, 32'd0, 32'd0,        0, 0, 2'b00, 32'd0,  1, 32'h0F,       3'b000, 1);
      add(1, 0, 32'd0,  32'd0,    0, 0, 32'd0, 32'd0,        0, 1, 2'b00, 32'd0,  0, 32'h0F,       3'b000, 1);

      for (int i = 0; i < vecs.size(); i++) begin
         rst_n = vecs[i].rn; rsp_ready = vecs[i].rr;
         req0_if.valid = vecs[i].v0; req0_if.a = vecs[i].a0; req0_if.b = vecs[i].b0; req0_if.op = vecs[i].op0;
         req1_if.valid = vecs[i].v1; req1_if.a = vecs[i].a1; req1_if.b = vecs[i].b1; req1_if.op = vecs[i].op1;
         @(negedge clk);
         check($sformatf("v%0d_ready", i), 64'({req1_if.ready, req0_if.ready}), 64'(vecs[i].e_rdy));
         check($sformatf("v%0d_alu_a", i), 64'(alu_a), 64'(vecs[i].e_alu_a));
         @(posedge clk);
         #1;
         check($sformatf("v%0d_rsp", i), 64'({rsp_valid, rsp_out, rsp_status, rsp_id}),
               64'({vecs[i].e_vld, vecs[i].e_out, vecs[i].e_st, vecs[i].e_id}));
      end

      // Both held valid with rr_ptr at 0: req1 must win on the second opportunity.
      rst_n = 1'b1; rsp_ready = 1'b1;
      req0_if.valid = 1; req0_if.a = 32'd1; req0_if.b = 32'd1;    req0_if.op = 3'd0;
      req1_if.valid = 1; req1_if.a = 32'd2; req1_if.b = 32'h55;   req1_if.op = 3'd6;
      found = 0;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         if (req1_if.ready) begin
            found = c;
            check("starve_alu_b_op", 64'({alu_op, alu_b}), 64'({3'd6, 32'h55}));
            break;
         end
         @(posedge clk);
         #1;
      end
      check("starve_wait", 64'(found), 64'd2);
      @(posedge clk);
      #1;
      req0_if.valid = 0; req1_if.valid = 0;
      check("starve_rsp", 64'({rsp_valid, rsp_out, rsp_status, rsp_id}),
            64'({1'b1, 32'h15, 3'b110, 1'b1}));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
